vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 32 +++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and coordinate type
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START  = DEF_H_VISIBLE + DEF_H_FP;
  localparam int DEF_HS_END    = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START  = DEF_V_VISIBLE + DEF_V_FP;
  localparam int DEF_VS_END    = DEF_VS_START + DEF_V_SYNC;

  // Half-open window test [lo, hi) on a raster coordinate.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping raster axis counter with terminal-count flag
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   tc
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  coord_t count_q;

  assign count = count_q;
  assign tc    = (count_q == LAST);

  // Written every cycle (hold included) so the state register has a single update path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tc ? '0 : count_q + 1'b1;
    end else begin
      count_q <= count_q;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: counters plus one aligned output register stage
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = DEF_H_VISIBLE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_VISIBLE   = DEF_V_VISIBLE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        sync,
  output coord_t      DrawX,
  output coord_t      DrawY,
  output logic        line_start,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t      hc;
  coord_t      vc;
  logic        h_tc;
  logic        v_tc_unused;
  logic [15:0] frame_cnt_q;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_hcnt (
    .clk   (vga_clk),
    .rst   (reset),
    .en    (1'b1),
    .count (hc),
    .tc    (h_tc)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_vcnt (
    .clk   (vga_clk),
    .rst   (reset),
    .en    (h_tc),
    .count (vc),
    .tc    (v_tc_unused)
  );

  logic at_line0;
  logic at_frame0;
  logic at_vblank;
  logic vis_now;
  logic hs_now;
  logic vs_now;

  always_comb begin
    at_line0  = (hc == '0);
    at_frame0 = at_line0 && (vc == '0);
    at_vblank = at_line0 && (vc == V_VIS_C);
    vis_now   = (hc < H_VIS_C) && (vc < V_VIS_C);
    hs_now    = in_window(hc, HS_START, HS_END);
    vs_now    = in_window(vc, VS_START, VS_END);
  end

  // Every output is decoded from the same (hc, vc) so all of them describe one pixel.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX        <= '0;
      DrawY        <= '0;
      blank        <= 1'b0;
      hs           <= ~SYNC_ACTIVE;
      vs           <= ~SYNC_ACTIVE;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      DrawX        <= hc;
      DrawY        <= vc;
      blank        <= vis_now;
      hs           <= hs_now ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs           <= vs_now ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      line_start   <= at_line0;
      frame_start  <= at_frame0;
      vblank_start <= at_vblank;
      frame_cnt_q  <= frame_cnt_q + {15'd0, at_vblank};
    end
  end

  assign sync        = 1'b0;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: full-size and reduced-geometry instances
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic        sync;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
    logic        vbs;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  logic f_hs, f_vs, f_blank, f_sync, f_ls, f_fs, f_vbs;
  logic s_hs, s_vs, s_blank, s_sync, s_ls, s_fs, s_vbs;
  coord_t f_x, f_y, s_x, s_y;
  logic [15:0] f_fc, s_fc;
  obs_t f_obs, s_obs;

  assign f_obs = {f_hs, f_vs, f_blank, f_sync, f_x, f_y, f_ls, f_fs, f_vbs, f_fc};
  assign s_obs = {s_hs, s_vs, s_blank, s_sync, s_x, s_y, s_ls, s_fs, s_vbs, s_fc};

  vga_timing_gen dut_f (
    .vga_clk(clk), .reset(reset), .hs(f_hs), .vs(f_vs), .blank(f_blank), .sync(f_sync),
    .DrawX(f_x), .DrawY(f_y), .line_start(f_ls), .frame_start(f_fs),
    .vblank_start(f_vbs), .frame_count(f_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_ACTIVE(1'b0)
  ) dut_s (
    .vga_clk(clk), .reset(reset), .hs(s_hs), .vs(s_vs), .blank(s_blank), .sync(s_sync),
    .DrawX(s_x), .DrawY(s_y), .line_start(s_ls), .frame_start(s_fs),
    .vblank_start(s_vbs), .frame_count(s_fc)
  );

  int n_checks = 0;
  int n_pass = 0;
  longint t_f = -1, t_s = -1;
  logic [15:0] fcb_f = '0, fcb_s = '0;

  // Line/frame statistics gathered from observed outputs.
  longint f_prev_ls = -1, s_prev_fs = -1;
  int f_hs_cnt, f_hs_min, f_hs_max, f_bl_cnt;
  int s_ls_cnt, s_vs_cnt, s_bl_cnt, s_max_x, s_max_y, f_max_x;

  // Expected outputs t edges after reset release, from raster arithmetic on the position.
  function automatic obs_t model(input int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp,
                                 input longint t, input logic [15:0] fc_base);
    longint ht, vt, ft, x, y, nvb;
    obs_t o;
    ht  = hv + hfp + hsw + hbp;
    vt  = vv + vfp + vsw + vbp;
    ft  = ht * vt;
    x   = t % ht;
    y   = (t / ht) % vt;
    nvb = t / ft + (((t % ft) >= vv * ht) ? 1 : 0);
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < hv) && (y < vv);
    o.hs    = !((x >= hv + hfp) && (x < hv + hfp + hsw));
    o.vs    = !((y >= vv + vfp) && (y < vv + vfp + vsw));
    o.sync  = 1'b0;
    o.ls    = (x == 0);
    o.fs    = (x == 0) && (y == 0);
    o.vbs   = (x == 0) && (y == vv);
    o.fc    = fc_base + 16'(nvb);
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h t_f=%0d t_s=%0d", tag, got, exp, t_f, t_s);
  endtask

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic clear_stats();
    f_prev_ls = -1; s_prev_fs = -1;
    f_hs_cnt = 0; f_hs_min = 9999; f_hs_max = -1; f_bl_cnt = 0;
    s_ls_cnt = 0; s_vs_cnt = 0; s_bl_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      t_f++;
      t_s++;
    end
    @(negedge clk);
    if (reset) begin
      check_obs("reset_f", f_obs, reset_obs());
      check_obs("reset_s", s_obs, reset_obs());
    end else begin
      check_obs("raster_f", f_obs, model(640, 16, 96, 48, 480, 10, 2, 33, t_f, fcb_f));
      check_obs("raster_s", s_obs, model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, t_s, fcb_s));
      if (f_ls) begin
        if (f_prev_ls >= 0) check_val("line_period_f", t_f - f_prev_ls, 800);
        if (f_y == 10'd1) begin
          check_val("hs_width_line0", f_hs_cnt, 96);
          check_val("hs_first_x", f_hs_min, 656);
          check_val("hs_last_x", f_hs_max, 751);
          check_val("blank_width_line0", f_bl_cnt, 640);
          check_val("drawx_max_f", f_max_x, 799);
        end
        if (f_y == 10'd0) begin
          f_hs_cnt = 0; f_hs_min = 9999; f_hs_max = -1; f_bl_cnt = 0; f_max_x = 0;
        end
        f_prev_ls = t_f;
      end
      if (f_y == 10'd0) begin
        if (!f_hs) begin
          f_hs_cnt++;
          if (int'(f_x) < f_hs_min) f_hs_min = int'(f_x);
          if (int'(f_x) > f_hs_max) f_hs_max = int'(f_x);
        end
        if (f_blank) f_bl_cnt++;
        if (int'(f_x) > f_max_x) f_max_x = int'(f_x);
      end
      if (s_fs) begin
        if (s_prev_fs >= 0) begin
          check_val("frame_period_s", t_s - s_prev_fs, 608);
          check_val("lines_per_frame_s", s_ls_cnt, 19);
          check_val("vs_cycles_s", s_vs_cnt, 64);
          check_val("visible_cycles_s", s_bl_cnt, 192);
          check_val("drawx_max_s", s_max_x, 31);
          check_val("drawy_max_s", s_max_y, 18);
        end
        s_ls_cnt = 0; s_vs_cnt = 0; s_bl_cnt = 0; s_max_x = 0; s_max_y = 0;
        s_prev_fs = t_s;
      end
      if (s_vbs) check_val("vblank_pos_s", {s_x, s_y}, {10'd0, 10'd12});
      if (s_ls) s_ls_cnt++;
      if (!s_vs) s_vs_cnt++;
      if (s_blank) s_bl_cnt++;
      if (int'(s_x) > s_max_x) s_max_x = int'(s_x);
      if (int'(s_y) > s_max_y) s_max_y = int'(s_y);
    end
  endtask

  task automatic release_reset();
    reset = 1'b0;
    t_f = -1; t_s = -1;
    fcb_f = '0; fcb_s = '0;
    clear_stats();
    tick();
    check_val("first_edge_fs_f", {f_fs, f_ls, f_blank}, 3'b111);
    check_val("first_edge_fs_s", {s_fs, s_ls, s_blank}, 3'b111);
  endtask

  initial begin
    int found;
    int n;
    clear_stats();
    s_max_x = 0; s_max_y = 0; f_max_x = 0;

    repeat (3) tick();
    release_reset();

    n = 3 * 608 + int'($urandom_range(0, 400));
    repeat (n) tick();

    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (s_fs) found = 1;
    end
    check_val("wait_frame_start", found, 1);

    // Preload the small instance's frame counter just below the wrap point.
    fcb_s = 16'hFFFF - model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, t_s, 16'd0).fc;
    force dut_s.frame_cnt_q = 16'hFFFF;
    repeat (2) tick();
    release dut_s.frame_cnt_q;
    check_val("preload_value", s_fc, 16'hFFFF);
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (s_vbs) found = 1;
    end
    check_val("wait_vblank", found, 1);
    check_val("frame_count_wrap", s_fc, 16'h0000);

    repeat (int'($urandom_range(50, 500))) tick();
    #($urandom_range(2, 15));
    reset = 1'b1;
    #1;
    check_obs("async_reset_f", f_obs, reset_obs());
    check_obs("async_reset_s", s_obs, reset_obs());
    @(negedge clk);
    repeat (3) tick();
    release_reset();

    n = 2 * 608 + int'($urandom_range(0, 300));
    repeat (n) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
